uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 1,
   parameter int FRAME_BITS = 10
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]         xmt_data,
   output logic                      load_XMT_datareg,
   output logic                      byte_ready,
   output logic                      t_byte,
   output logic                      busy,
   output logic [2:0]                active_id,
   output logic [2:0]                state_o
);

   localparam int FRAME_CYC = FRAME_BITS * BIT_CYCLES;
   localparam int CNT_W     = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYC - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      READY = 3'd2,
      START = 3'd3,
      WAIT  = 3'd4
   } state_t;

   state_t              state_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [DATA_W-1:0]   xmt_q;
   logic                load_q;
   logic                br_q;
   logic                tb_q;
   logic                busy_q;
   logic [2:0]          id_q;
   logic [2:0]          ptr_q;
   logic [2:0]          ptr_d;
   logic [CNT_W-1:0]    cnt_q;

   logic                win_found;
   logic [2:0]          win_idx;
   logic [DATA_W-1:0]   win_data;

   // Handshake: a requester holds req[i] (and its data slice) until it sees
   // gnt[i] for one cycle; the byte was captured on the edge that raised gnt.
   always_comb begin
      int s;
      win_found = 1'b0;
      win_idx   = '0;
      s         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         s = int'(ptr_q) + i;
         if (s >= NUM_REQ) s = s - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && (s == j) && req[j]) begin
               win_found = 1'b1;
               win_idx   = 3'(j);
            end
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win_idx == 3'(j)) win_data = req_data[j*DATA_W +: DATA_W];
      end
   end

   // Fixed priority keeps the search origin pinned at requester 0.
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
   assign ptr_d = '0;
`else
   assign ptr_d = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         xmt_q   <= '0;
         load_q  <= 1'b0;
         br_q    <= 1'b0;
         tb_q    <= 1'b0;
         busy_q  <= 1'b0;
         id_q    <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               gnt_q  <= '0;
               load_q <= 1'b0;
               br_q   <= 1'b0;
               tb_q   <= 1'b0;
               if (win_found) begin
                  state_q <= LOAD;
                  xmt_q   <= win_data;
                  id_q    <= win_idx;
                  ptr_q   <= ptr_d;
                  gnt_q   <= NUM_REQ'(1) << win_idx;
                  load_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               state_q <= READY;
               gnt_q   <= '0;
               load_q  <= 1'b0;
               br_q    <= 1'b1;
            end
            READY: begin
               state_q <= START;
               tb_q    <= 1'b1;
            end
            START: begin
               state_q <= WAIT;
               br_q    <= 1'b0;
               tb_q    <= 1'b0;
               cnt_q   <= CNT_LOAD;
            end
            WAIT: begin
               // Hold the transmitter for the full serial frame.
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               load_q  <= 1'b0;
               br_q    <= 1'b0;
               tb_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt              = gnt_q;
   assign xmt_data         = xmt_q;
   assign load_XMT_datareg = load_q;
   assign byte_ready       = br_q;
   assign t_byte           = tb_q;
   assign busy             = busy_q;
   assign active_id        = id_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic against a timing model.
module tb_uart_tx_scheduler;

   localparam int NUM_REQ    = 4;
   localparam int DATA_W     = 8;
   localparam int BIT_CYCLES = 1;
   localparam int FRAME_BITS = 10;
   localparam int F          = FRAME_BITS * BIT_CYCLES;
   localparam int PERIOD     = 1 + 3 + F;

   logic                      clock = 1'b0;
   logic                      resetn = 1'b0;
   logic [NUM_REQ-1:0]        req = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        gnt;
   logic [DATA_W-1:0]         xmt_data;
   logic                      load_XMT_datareg;
   logic                      byte_ready;
   logic                      t_byte;
   logic                      busy;
   logic [2:0]                active_id;
   logic [2:0]                state_o;

   int checks = 0;
   int pass_cnt = 0;
   int k = 0;

   int          m_ptr, m_load, m_free, m_id;
   logic [7:0]  m_data;
   logic [18:0] exp_vec;
   logic [18:0] obs_vec;
   logic [2:0]  exp_q[$];

   assign obs_vec = {gnt, load_XMT_datareg, byte_ready, t_byte, busy, xmt_data, active_id};

   always #5 clock = ~clock;

   uart_tx_scheduler #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BIT_CYCLES(BIT_CYCLES), .FRAME_BITS(FRAME_BITS)
   ) dut (
      .clock(clock), .resetn(resetn), .req(req), .req_data(req_data),
      .gnt(gnt), .xmt_data(xmt_data), .load_XMT_datareg(load_XMT_datareg),
      .byte_ready(byte_ready), .t_byte(t_byte), .busy(busy),
      .active_id(active_id), .state_o(state_o)
   );

   task automatic model_reset();
      m_ptr  = 0;
      m_load = -1000;
      m_free = -1000;
      m_id   = 0;
      m_data = '0;
   endtask

   // Reference: a byte is granted one cycle after the scheduler is free and sees any
   // request; it then owns the transmitter for PERIOD cycles.
   task automatic step();
      int  w, d, idx;
      bit  found;
      found = 1'b0;
      w = 0;
      if (k >= m_free && req != '0) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            idx = (m_ptr + j) % NUM_REQ;
            if (!found && req[idx]) begin
               found = 1'b1;
               w = idx;
            end
         end
         m_load = k + 1;
         m_free = m_load + PERIOD - 1;
         m_id   = w;
         m_data = req_data[w*DATA_W +: DATA_W];
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
         m_ptr  = (w + 1) % NUM_REQ;
`endif
      end
      @(posedge clock);
      #1;
      k++;
      d = k - m_load;
      exp_vec = {(d == 0) ? 4'(1 << m_id) : 4'b0000, d == 0, (d == 1) || (d == 2), d == 2,
                 (d >= 0) && (d <= 2 + F), m_data, 3'(m_id)};
   endtask

   task automatic do_reset();
      req = '0;
      resetn = 1'b0;
      #2;
      @(posedge clock);
      #1;
      k++;
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      req = '0;
      resetn = 1'b0;
      #2;
      checks++;
      if (obs_vec !== 19'd0) $display("FAIL reset_outputs got=%h exp=%h", obs_vec, 19'd0);
      else pass_cnt++;
      checks++;
      if (state_o !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state_o);
      else pass_cnt++;
      @(posedge clock);
      #1;
      k++;
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      req = 4'b0001;
      req_data[7:0] = 8'h5A;
      step();
      checks++;
      if (obs_vec !== exp_vec) $display("FAIL midrst_load cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < 6; i++) step();
      resetn = 1'b0;
      #1;
      checks++;
      if (obs_vec !== 19'd0) $display("FAIL midrst_outputs got=%h exp=%h", obs_vec, 19'd0);
      else pass_cnt++;
      checks++;
      if (state_o !== 3'd0) $display("FAIL midrst_state got=%0d exp=0", state_o);
      else pass_cnt++;
      @(posedge clock);
      #1;
      k++;
      resetn = 1'b1;
      model_reset();
      req = 4'b0001;
      req_data[7:0] = 8'h3C;
      step();
      checks++;
      if (gnt !== 4'b0001) $display("FAIL midrst_regrant got=%b exp=0001", gnt);
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < PERIOD; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL midrst_frame cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
         else pass_cnt++;
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      req_data[7:0] = 8'hA6;
      step();
      checks++;
      if (gnt !== 4'b0001 || load_XMT_datareg !== 1'b1 || xmt_data !== 8'hA6)
         $display("FAIL single_load got=%b/%b/%h exp=0001/1/a6", gnt, load_XMT_datareg, xmt_data);
      else pass_cnt++;
      req = '0;
      for (int i = 1; i <= PERIOD + 1; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL single_frame cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
         else pass_cnt++;
         if (i == 2 + F) begin
            checks++;
            if (busy !== 1'b1) $display("FAIL single_busy_last got=%b exp=1", busy);
            else pass_cnt++;
         end
         if (i == 3 + F) begin
            checks++;
            if (busy !== 1'b0) $display("FAIL single_busy_drop got=%b exp=0", busy);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_simultaneous();
      int last_cyc, id;
      do_reset();
      req = 4'b1111;
      req_data = {8'h43, 8'h32, 8'h21, 8'h10};
      exp_q = {3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      last_cyc = -1;
      for (int i = 0; i < 4 * PERIOD + 4; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL simul_frame cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
         else pass_cnt++;
         if (gnt != '0) begin
            id = 0;
            for (int j = 0; j < NUM_REQ; j++) if (gnt[j]) id = j;
            checks++;
            if (exp_q.size() == 0) $display("FAIL simul_extra_grant got=%0d exp=none", id);
            else if (3'(id) !== exp_q[0]) $display("FAIL simul_order got=%0d exp=%0d", id, exp_q[0]);
            else pass_cnt++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (last_cyc >= 0) begin
               checks++;
               if (k - last_cyc !== PERIOD) $display("FAIL simul_spacing got=%0d exp=%0d", k - last_cyc, PERIOD);
               else pass_cnt++;
            end
            last_cyc = k;
         end
      end
      checks++;
      if (exp_q.size() != 0) $display("FAIL simul_missing got=%0d left exp=0", exp_q.size());
      else pass_cnt++;
      req = '0;
   endtask

   task automatic test_pending();
      int first_cyc, g_cyc;
      do_reset();
      req = 4'b0001;
      req_data[7:0] = 8'h11;
      step();
      first_cyc = k;
      req = '0;
      for (int i = 0; i < 4; i++) step();
      req = 4'b0100;
      req_data[23:16] = 8'hC6;
      g_cyc = -1;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL pending_frame cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
         else pass_cnt++;
         if (gnt[2]) begin
            g_cyc = k;
            req = '0;
            checks++;
            if (xmt_data !== 8'hC6) $display("FAIL pending_data got=%h exp=c6", xmt_data);
            else pass_cnt++;
         end
      end
      checks++;
      if (g_cyc - first_cyc !== PERIOD) $display("FAIL pending_grant_delay got=%0d exp=%0d", g_cyc - first_cyc, PERIOD);
      else pass_cnt++;
   endtask

   task automatic test_withdrawn();
      int seen1;
      do_reset();
      req = 4'b0001;
      req_data[7:0] = 8'h22;
      step();
      req = '0;
      for (int i = 0; i < 5; i++) step();
      seen1 = 0;
      for (int i = 0; i < PERIOD + 4; i++) begin
         req = (i < 3) ? 4'b0010 : 4'b0000;
         req_data[15:8] = 8'h77;
         step();
         if (gnt[1]) seen1++;
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL withdrawn_frame cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
         else pass_cnt++;
      end
      checks++;
      if (seen1 !== 0) $display("FAIL withdrawn_grant got=%0d exp=0", seen1);
      else pass_cnt++;
      checks++;
      if (busy !== 1'b0) $display("FAIL withdrawn_idle got=%b exp=0", busy);
      else pass_cnt++;
   endtask

   task automatic test_two_held();
      int n1, n2, e1, e2;
      do_reset();
      req = 4'b0110;
      req_data = {8'h00, 8'hC2, 8'hB1, 8'h00};
      n1 = 0;
      n2 = 0;
      for (int i = 0; i < 4 * PERIOD + 2; i++) begin
         step();
         if (gnt[1]) n1++;
         if (gnt[2]) n2++;
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL two_held_frame cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
         else pass_cnt++;
      end
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
      e1 = 5;
      e2 = 0;
`else
      e1 = 3;
      e2 = 2;
`endif
      checks++;
      if (n1 !== e1 || n2 !== e2) $display("FAIL two_held_counts got=%0d/%0d exp=%0d/%0d", n1, n2, e1, e2);
      else pass_cnt++;
      req = '0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (!req[r] && $urandom_range(0, 3) == 0) begin
               req[r] = 1'b1;
               req_data[r*DATA_W +: DATA_W] = 8'($urandom);
            end else if (req[r] && $urandom_range(0, 19) == 0) begin
               req[r] = 1'b0;
            end
         end
         step();
         checks++;
         if (obs_vec !== exp_vec) $display("FAIL random_frame cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec);
         else pass_cnt++;
         for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
               if ($urandom_range(0, 1) == 0) req[r] = 1'b0;
               else req_data[r*DATA_W +: DATA_W] = 8'($urandom);
            end
         end
      end
      req = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_reset_mid_frame();
      test_single();
      test_simultaneous();
      test_pending();
      test_withdrawn();
      test_two_held();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, checks);
      $finish;
   end

endmodule
